// File: rtl/fetch_pc_unit_pkg.sv
// Shared constants and FSM encoding for the PC generation / instruction fetch stage.
package fetch_pc_unit_pkg;

    localparam int DEF_ADR_BIT  = 32;
    localparam int DEF_ISC_BIT  = 32;
    localparam int DEF_RESET_PC = 0;
    localparam int DEF_PC_INC   = 4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_HOLD  = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_pc_unit_if.sv
// Instruction-memory req/ack port: the fetch unit is master, the memory is slave.
interface fetch_pc_unit_if
    import fetch_pc_unit_pkg::*;
#(
    parameter int ADR_BIT = DEF_ADR_BIT,
    parameter int ISC_BIT = DEF_ISC_BIT
);
    logic               req;
    logic [ADR_BIT-1:0] addr;
    logic               ack;
    logic [ISC_BIT-1:0] rdata;

    modport master (output req, addr, input ack, rdata);
    modport slave  (input req, addr, output ack, rdata);
endinterface

// File: rtl/fetch_hold_buf.sv
// One-entry skid register catching an ack that arrives while IF/ID is stalled and full.
module fetch_hold_buf #(
    parameter int ADR_BIT = 32,
    parameter int ISC_BIT = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               clear,
    input  logic [ISC_BIT-1:0] inst_in,
    input  logic [ADR_BIT-1:0] pc_next_in,
    output logic               hold_valid,
    output logic [ISC_BIT-1:0] hold_inst,
    output logic [ADR_BIT-1:0] hold_pc_next
);

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_valid   <= 1'b0;
            hold_inst    <= '0;
            hold_pc_next <= '0;
        end else if (clear) begin
            hold_valid <= 1'b0;
        end else if (load) begin
            hold_valid   <= 1'b1;
            hold_inst    <= inst_in;
            hold_pc_next <= pc_next_in;
        end
    end

endmodule

// File: rtl/fetch_pc_unit.sv
// PC generation and instruction fetch: redirect selection, req/ack memory port,
// IF/ID output register and squash generation.
module fetch_pc_unit
    import fetch_pc_unit_pkg::*;
#(
    parameter int                 ADR_BIT  = DEF_ADR_BIT,
    parameter int                 ISC_BIT  = DEF_ISC_BIT,
    parameter logic [ADR_BIT-1:0] RESET_PC = ADR_BIT'(DEF_RESET_PC),
    parameter int                 PC_INC   = DEF_PC_INC
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    input  logic               branch_jump_flag,
    input  logic [ADR_BIT-1:0] branch_addr_ex,
    input  logic               id_jump_flag,
    input  logic [ADR_BIT-1:0] branch_addr_id,
    fetch_pc_unit_if.master    imem,
    output logic [ISC_BIT-1:0] if_inst,
    output logic [ADR_BIT-1:0] if_pc_next,
    output logic               if_valid,
    output logic               flush_id,
    output logic               flush_ex
);

    fetch_state_t       state;
    logic [ADR_BIT-1:0] pc, pc_d, pc_inc, target, addr_q;
    logic               req_q, drop;
    logic               ex_redir, id_redir, redirect, slot_free;
    logic               good_ack, load_hold, unload_hold;
    logic               hold_valid;
    logic [ISC_BIT-1:0] hold_inst;
    logic [ADR_BIT-1:0] hold_pc_next;

    assign ex_redir  = branch_jump_flag;
    assign id_redir  = id_jump_flag & ~stall & ~branch_jump_flag;
    assign redirect  = ex_redir | id_redir;
    assign target    = ex_redir ? branch_addr_ex : branch_addr_id;
    assign flush_id  = redirect;
    assign flush_ex  = ex_redir;
    assign slot_free = ~if_valid | ~stall;
    assign pc_inc    = pc + ADR_BIT'(PC_INC);

    // Only an ack for the live request, not overtaken by a redirect, carries usable data.
    assign good_ack    = req_q & imem.ack & ~drop & ~redirect;
    assign load_hold   = good_ack & ~slot_free;
    assign unload_hold = (state == S_HOLD) & ~stall & ~redirect;

    always_comb begin
        pc_d = pc;
        if (redirect)      pc_d = target;
        else if (good_ack) pc_d = pc_inc;
    end

    assign imem.req  = req_q;
    assign imem.addr = addr_q;

    fetch_hold_buf #(.ADR_BIT(ADR_BIT), .ISC_BIT(ISC_BIT)) u_hold (
        .clk          (clk),
        .rst          (rst),
        .load         (load_hold),
        .clear        (redirect | unload_hold),
        .inst_in      (imem.rdata),
        .pc_next_in   (pc_inc),
        .hold_valid   (hold_valid),
        .hold_inst    (hold_inst),
        .hold_pc_next (hold_pc_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            pc         <= RESET_PC;
            addr_q     <= RESET_PC;
            state      <= S_IDLE;
            req_q      <= 1'b0;
            drop       <= req_q;
            if_valid   <= 1'b0;
            if_inst    <= '0;
            if_pc_next <= '0;
        end else begin
            pc <= pc_d;
            // A request waiting for its ack keeps its address even across a redirect.
            if (!(req_q && !imem.ack))
                addr_q <= pc_d;

            if (redirect && req_q && !imem.ack)
                drop <= 1'b1;
            else if (imem.ack)
                drop <= 1'b0;

            if (redirect) begin
                if_valid <= 1'b0;
            end else if (good_ack && slot_free) begin
                if_inst    <= imem.rdata;
                if_pc_next <= pc_inc;
                if_valid   <= 1'b1;
            end else if (unload_hold) begin
                if_inst    <= hold_inst;
                if_pc_next <= hold_pc_next;
                if_valid   <= hold_valid;
            end else if (!stall) begin
                if_valid <= 1'b0;
            end

            if (redirect) begin
                state <= S_FETCH;
                req_q <= 1'b1;
            end else begin
                case (state)
                    S_IDLE: begin
                        state <= S_FETCH;
                        req_q <= 1'b1;
                    end
                    S_FETCH: if (load_hold) begin
                        state <= S_HOLD;
                        req_q <= 1'b0;
                    end
                    S_HOLD: if (!stall) begin
                        state <= S_FETCH;
                        req_q <= 1'b1;
                    end
                    default: begin
                        state <= S_IDLE;
                        req_q <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed plus randomized bench for fetch_pc_unit against a program-order reference model.
module tb_fetch_pc_unit;

    logic        clk = 1'b0;
    logic        rst, stall, bj, idj;
    logic [31:0] addr_ex, addr_id;
    logic [31:0] if_inst, if_pc_next;
    logic        if_valid, flush_id, flush_ex;

    int          errors = 0;
    int          checks = 0;

    fetch_pc_unit_if #(.ADR_BIT(32), .ISC_BIT(32)) m ();

    fetch_pc_unit dut (
        .clk              (clk),
        .rst              (rst),
        .stall            (stall),
        .branch_jump_flag (bj),
        .branch_addr_ex   (addr_ex),
        .id_jump_flag     (idj),
        .branch_addr_id   (addr_id),
        .imem             (m),
        .if_inst          (if_inst),
        .if_pc_next       (if_pc_next),
        .if_valid         (if_valid),
        .flush_id         (flush_id),
        .flush_ex         (flush_ex)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
    endfunction

    // Memory: acks once the live request has waited mem_lat cycles (0 = same cycle).
    int  fixed_lat = 0;
    int  rnd_lat   = 0;
    int  cnt       = 0;
    bit  rand_mode = 1'b0;
    int  mem_lat;
    assign mem_lat = rand_mode ? rnd_lat : fixed_lat;
    assign m.ack   = m.req && (cnt >= mem_lat);
    assign m.rdata = mem_word(m.addr);

    always @(posedge clk) begin
        if (rst || !m.req || m.ack) begin
            cnt     <= 0;
            rnd_lat <= int'($urandom_range(0, 3));
        end else begin
            cnt <= cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference: the IF/ID consumer sees the program stream in order; a redirect restarts it.
    logic [31:0] exp_pc = 32'h0;
    bit          hold_pend = 1'b0, wait_pend = 1'b0;
    logic [31:0] held_pc, held_inst, wait_addr;
    int          delivered = 0;

    task automatic model_step();
        logic        redir;
        logic [31:0] tgt;
        if (rst) begin
            exp_pc    = 32'h0;
            hold_pend = 1'b0;
            wait_pend = 1'b0;
            return;
        end
        redir = bj | (idj & ~stall);
        tgt   = bj ? addr_ex : addr_id;
        check("flush_id", 64'(flush_id), 64'(redir));
        check("flush_ex", 64'(flush_ex), 64'(bj));
        if (wait_pend) begin
            check("req_held", 64'(m.req), 64'd1);
            check("addr_held", 64'(m.addr), 64'(wait_addr));
        end
        if (hold_pend) begin
            check("stall_valid", 64'(if_valid), 64'd1);
            check("stall_pc", 64'(if_pc_next), 64'(held_pc));
            check("stall_inst", 64'(if_inst), 64'(held_inst));
        end
        if (redir) begin
            exp_pc = tgt;
        end else if (if_valid && !stall) begin
            check("order_pc", 64'(if_pc_next), 64'(exp_pc + 32'd4));
            check("order_inst", 64'(if_inst), 64'(mem_word(exp_pc)));
            exp_pc = exp_pc + 32'd4;
            delivered++;
        end
        hold_pend = if_valid && stall && !redir;
        held_pc   = if_pc_next;
        held_inst = if_inst;
        wait_pend = m.req && !m.ack;
        wait_addr = m.addr;
    endtask

    task automatic step();
        model_step();
        @(negedge clk);
    endtask

    initial begin
        int start;
        rst = 1'b1; stall = 1'b0; bj = 1'b0; idj = 1'b0;
        addr_ex = '0; addr_id = '0;
        repeat (3) step();

        rst = 1'b0; #1;
        check("rst_valid", 64'(if_valid), 64'd0);
        check("rst_inst", 64'(if_inst), 64'd0);
        check("rst_pc_next", 64'(if_pc_next), 64'd0);
        check("rst_req", 64'(m.req), 64'd0);
        check("rst_addr", 64'(m.addr), 64'd0);
        step();

        // zero-latency memory, no stalls
        #1; check("z_req", 64'(m.req), 64'd1); check("z_addr0", 64'(m.addr), 64'h0); step();
        #1; check("z_valid", 64'(if_valid), 64'd1); check("z_pcn4", 64'(if_pc_next), 64'h4);
            check("z_addr4", 64'(m.addr), 64'h4); step();
        #1; check("z_pcn8", 64'(if_pc_next), 64'h8); check("z_addr8", 64'(m.addr), 64'h8); step();

        // three-cycle request window
        fixed_lat = 2; #1;
        check("z_pcnC", 64'(if_pc_next), 64'hC); check("l_addr_a", 64'(m.addr), 64'hC); step();
        #1; check("l_bubble_a", 64'(if_valid), 64'd0); check("l_addr_b", 64'(m.addr), 64'hC);
            check("l_req", 64'(m.req), 64'd1); step();
        #1; check("l_bubble_b", 64'(if_valid), 64'd0); check("l_addr_c", 64'(m.addr), 64'hC); step();

        // stall over the 0x10 fetch, ack lands in the second stall cycle
        fixed_lat = 1; stall = 1'b1; #1;
        check("l_pulse", 64'(if_valid), 64'd1); check("s_addr10", 64'(m.addr), 64'h10); step();
        #1; check("s_ack", 64'(m.ack), 64'd1); check("s_keep_pc", 64'(if_pc_next), 64'h10); step();
        #1; check("s_req_off", 64'(m.req), 64'd0); check("s_keep_v", 64'(if_valid), 64'd1); step();
        #1; check("s_keep_inst", 64'(if_inst), 64'(mem_word(32'hC))); step();
        stall = 1'b0; #1; step();
        fixed_lat = 0; #1;
        check("s_inst10", 64'(if_inst), 64'(mem_word(32'h10)));
        check("s_pcn14", 64'(if_pc_next), 64'h14); check("s_addr14", 64'(m.addr), 64'h14); step();

        // EX and ID redirect together: EX wins
        bj = 1'b1; addr_ex = 32'h100; idj = 1'b1; addr_id = 32'h200; #1;
        check("r_flush_id", 64'(flush_id), 64'd1); check("r_flush_ex", 64'(flush_ex), 64'd1); step();
        bj = 1'b0; idj = 1'b0; #1;
        check("r_addr100", 64'(m.addr), 64'h100); check("r_valid", 64'(if_valid), 64'd0); step();

        // ID redirect to 0x40 while 0x20 is outstanding
        bj = 1'b1; addr_ex = 32'h20; #1; step();
        bj = 1'b0; fixed_lat = 2; idj = 1'b1; addr_id = 32'h40; #1;
        check("d_addr20", 64'(m.addr), 64'h20); check("d_noack", 64'(m.ack), 64'd0); step();
        idj = 1'b0; #1; check("d_addr20b", 64'(m.addr), 64'h20); step();
        #1; check("d_stale_ack", 64'(m.ack), 64'd1); step();
        fixed_lat = 0; #1;
        check("d_addr40", 64'(m.addr), 64'h40); check("d_valid0", 64'(if_valid), 64'd0); step();

        // ID jump under stall is deferred, then taken once
        stall = 1'b1; idj = 1'b1; addr_id = 32'h80; #1;
        check("j_pcn44", 64'(if_pc_next), 64'h44); check("j_inst40", 64'(if_inst), 64'(mem_word(32'h40)));
        check("j_noflush_a", 64'(flush_id), 64'd0); step();
        #1; check("j_noflush_b", 64'(flush_id), 64'd0); step();
        stall = 1'b0; #1; check("j_flush", 64'(flush_id), 64'd1); step();
        idj = 1'b0; #1;
        check("j_addr80", 64'(m.addr), 64'h80); check("j_once", 64'(flush_id), 64'd0);
        check("j_valid0", 64'(if_valid), 64'd0); step();
        #1; check("j_pcn84", 64'(if_pc_next), 64'h84); step();

        // randomized traffic with one mid-run reset
        rand_mode = 1'b1;
        start = delivered;
        for (int i = 0; i < 400; i++) begin
            rst     = (i == 200) || (i == 201);
            stall   = ($urandom_range(0, 99) < 30);
            bj      = !rst && ($urandom_range(0, 99) < 5);
            idj     = !rst && ($urandom_range(0, 99) < 8);
            addr_ex = 32'($urandom_range(0, 1023)) << 2;
            addr_id = 32'($urandom_range(0, 1023)) << 2;
            #1;
            step();
        end
        check("rand_progress", 64'(delivered - start >= 20), 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
